// File: rtl/beep_sequencer_if.sv
// Pattern request channel for beep_sequencer: valid/ready handshake
// carrying beep count plus on/off durations in ms.
interface beep_sequencer_if #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned MS_W  = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [CNT_W-1:0] req_count;
    logic [MS_W-1:0]  req_on_ms;
    logic [MS_W-1:0]  req_off_ms;

    modport master (
        output req_valid, req_count, req_on_ms, req_off_ms,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_count, req_on_ms, req_off_ms,
        output req_ready
    );
endinterface

// File: rtl/beep_sequencer.sv
// Plays N active-low beeps of on_ms each, separated by off_ms gaps.
// One pattern at a time; abort returns to IDLE, mute only masks the pin.
module beep_sequencer #(
    parameter int unsigned TICK_CYCLES = 50_000,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned MS_W        = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    beep_sequencer_if.slave      req,
    input  logic                 abort,
    input  logic                 mute,
    output logic                 busy,
    output logic                 done,
    output logic                 beep
);

    localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PRE_W-1:0] presc_q;
    logic [MS_W-1:0]  ms_q;
    logic [MS_W-1:0]  on_q;
    logic [MS_W-1:0]  off_q;
    logic [MS_W-1:0]  phase_len;
    logic [CNT_W-1:0] rem_q;
    logic             ready_c;
    logic             accept;
    logic             start;
    logic             tick;
    logic             phase_end;
    logic             last_beep;
    logic             beep_q;
    logic             beep_d;
    logic             busy_d;
    logic             done_d;

    assign ready_c       = (state_q == ST_IDLE) && !sys_rst;
    assign req.req_ready = ready_c;
    assign accept        = req.req_valid && ready_c;
    assign start         = accept && (req.req_count != '0);
    assign tick          = (presc_q == PRE_W'(TICK_CYCLES - 1));
    assign phase_len     = (state_q == ST_OFF) ? off_q : on_q;
    assign phase_end     = tick && (ms_q == phase_len - MS_W'(1));
    assign last_beep     = (rem_q == CNT_W'(1));
    assign beep          = beep_q | mute;

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks a phase ending in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_ON;
            ST_ON: begin
                if (abort)          state_d = ST_IDLE;
                else if (phase_end) state_d = last_beep ? ST_IDLE : ST_OFF;
            end
            ST_OFF: begin
                if (abort)          state_d = ST_IDLE;
                else if (phase_end) state_d = ST_ON;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode, registered alongside the state
    always_comb begin
        beep_d = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_d == ST_ON) beep_d = 1'b0;
        if (state_d != ST_IDLE) busy_d = 1'b1;
        if (accept && (req.req_count == '0)) done_d = 1'b1;
        if ((state_q == ST_ON) && !abort && phase_end && last_beep) done_d = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            beep_q <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            beep_q <= beep_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

    // Request latch, remaining-beep counter, ms prescaler and phase timer
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rem_q   <= '0;
            on_q    <= '0;
            off_q   <= '0;
            presc_q <= '0;
            ms_q    <= '0;
        end else begin
            if (start) begin
                rem_q <= req.req_count;
                on_q  <= (req.req_on_ms  == '0) ? MS_W'(1) : req.req_on_ms;
                off_q <= (req.req_off_ms == '0) ? MS_W'(1) : req.req_off_ms;
            end else if ((state_q == ST_ON) && !abort && phase_end) begin
                rem_q <= rem_q - CNT_W'(1);
            end

            if ((state_d != state_q) || (state_q == ST_IDLE)) begin
                presc_q <= '0;
                ms_q    <= '0;
            end else if (tick) begin
                presc_q <= '0;
                ms_q    <= ms_q + MS_W'(1);
            end else begin
                presc_q <= presc_q + PRE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_beep_sequencer.sv
// Self-checking bench for beep_sequencer: vector table, corner sequences
// and randomized patterns compared against an arithmetic pattern model.
module tb_beep_sequencer;

    localparam int unsigned T = 4;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic abort   = 1'b0;
    logic mute    = 1'b0;
    logic busy;
    logic done;
    logic beep;

    int n_cmp = 0;
    int n_err = 0;

    beep_sequencer_if #(.CNT_W(4), .MS_W(8)) bus ();

    beep_sequencer #(.TICK_CYCLES(T), .CNT_W(4), .MS_W(8)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (bus),
        .abort   (abort),
        .mute    (mute),
        .busy    (busy),
        .done    (done),
        .beep    (beep)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int cnt;
        int on;
        int off;
        bit mt;
        int exp_busy;
        int exp_low;
        int exp_done;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present a request at a negedge; returns at the first negedge after acceptance
    task automatic start_req(input int c, input int on, input int off);
        chk("ready before request", int'(bus.req_ready), 1);
        bus.req_valid  = 1'b1;
        bus.req_count  = 4'(c);
        bus.req_on_ms  = 8'(on);
        bus.req_off_ms = 8'(off);
        @(negedge sys_clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge sys_clk);
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int total_len(input int c, input int on, input int off);
        if (c == 0) return 0;
        return (c * eff(on) + (c - 1) * eff(off)) * int'(T);
    endfunction

    // Beep level j cycles after acceptance, from the pattern's period arithmetic
    function automatic int exp_beep(input int j, input int c, input int on, input int off, input bit m);
        int per;
        if (m) return 1;
        if (j >= total_len(c, on, off)) return 1;
        per = (eff(on) + eff(off)) * int'(T);
        return ((j % per) < eff(on) * int'(T)) ? 0 : 1;
    endfunction

    int nb, nl, nd, dpos, tot, rc, ron, roff;
    bit rm;

    initial begin
        vecs[0] = '{cnt: 1, on: 2, off: 5, mt: 1'b0, exp_busy:  8, exp_low:  8, exp_done: 1};
        vecs[1] = '{cnt: 3, on: 1, off: 2, mt: 1'b0, exp_busy: 28, exp_low: 12, exp_done: 1};
        vecs[2] = '{cnt: 0, on: 3, off: 3, mt: 1'b0, exp_busy:  0, exp_low:  0, exp_done: 1};
        vecs[3] = '{cnt: 2, on: 2, off: 3, mt: 1'b1, exp_busy: 28, exp_low:  0, exp_done: 1};
        vecs[4] = '{cnt: 2, on: 0, off: 0, mt: 1'b0, exp_busy: 12, exp_low:  8, exp_done: 1};

        bus.req_valid  = 1'b0;
        bus.req_count  = '0;
        bus.req_on_ms  = '0;
        bus.req_off_ms = '0;

        // Reset state
        step(3);
        chk("reset ready", int'(bus.req_ready), 0);
        chk("reset beep", int'(beep), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        sys_rst = 1'b0;
        #1;
        chk("ready after reset", int'(bus.req_ready), 1);
        step(1);

        // Table-driven patterns
        for (int v = 0; v < 5; v++) begin
            nb = 0; nl = 0; nd = 0; dpos = -1;
            mute = vecs[v].mt;
            start_req(vecs[v].cnt, vecs[v].on, vecs[v].off);
            for (int j = 0; j < 60; j++) begin
                if (busy) nb++;
                if (!beep) nl++;
                if (done) begin
                    nd++;
                    if (dpos < 0) dpos = j;
                end
                @(negedge sys_clk);
            end
            mute = 1'b0;
            chk($sformatf("vec%0d busy cycles", v), nb, vecs[v].exp_busy);
            chk($sformatf("vec%0d beep low cycles", v), nl, vecs[v].exp_low);
            chk($sformatf("vec%0d done pulses", v), nd, vecs[v].exp_done);
            chk($sformatf("vec%0d done position", v), dpos, vecs[v].exp_busy);
        end

        // Held request during a pattern: changed fields ignored, accepted at completion
        bus.req_valid  = 1'b1;
        bus.req_count  = 4'd1;
        bus.req_on_ms  = 8'd1;
        bus.req_off_ms = 8'd1;
        @(negedge sys_clk);
        bus.req_on_ms = 8'd2;
        chk("held: ready low while busy", int'(bus.req_ready), 0);
        step(3);
        chk("held: first beep still on", int'(beep), 0);
        step(1);
        chk("held: done at completion", int'(done), 1);
        chk("held: beep off at completion", int'(beep), 1);
        chk("held: ready at completion", int'(bus.req_ready), 1);
        step(1);
        bus.req_valid = 1'b0;
        chk("held: second accepted busy", int'(busy), 1);
        chk("held: second accepted beep", int'(beep), 0);
        step(7);
        chk("held: second beep last cycle", int'(beep), 0);
        step(1);
        chk("held: second done", int'(done), 1);
        chk("held: second beep off", int'(beep), 1);
        step(1);

        // Abort mid second beep, then immediate new request
        start_req(5, 3, 2);
        step(26);
        chk("abort: in second beep", int'(beep), 0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort: beep", int'(beep), 1);
        chk("abort: busy", int'(busy), 0);
        chk("abort: done", int'(done), 0);
        chk("abort: ready", int'(bus.req_ready), 1);
        start_req(1, 1, 1);
        chk("after abort: busy", int'(busy), 1);
        chk("after abort: beep", int'(beep), 0);
        step(4);
        chk("after abort: done", int'(done), 1);
        step(1);

        // Abort in the same cycle the final beep would end
        start_req(1, 1, 1);
        step(3);
        chk("abort at end: still on", int'(beep), 0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort at end: no done", int'(done), 0);
        chk("abort at end: busy", int'(busy), 0);
        step(1);

        // Reset during OFF
        start_req(4, 1, 2);
        step(6);
        chk("rst test: in OFF beep", int'(beep), 1);
        chk("rst test: in OFF busy", int'(busy), 1);
        sys_rst = 1'b1;
        step(1);
        chk("rst test: ready during reset", int'(bus.req_ready), 0);
        chk("rst test: beep", int'(beep), 1);
        chk("rst test: busy", int'(busy), 0);
        sys_rst = 1'b0;
        #1;
        chk("rst test: ready", int'(bus.req_ready), 1);
        nd = 0; nl = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge sys_clk);
            if (done) nd++;
            if (!beep) nl++;
        end
        chk("rst test: no done", nd, 0);
        chk("rst test: no beep", nl, 0);

        // Randomized patterns against the model
        for (int r = 0; r < 40; r++) begin
            rc   = int'($urandom_range(0, 4));
            ron  = int'($urandom_range(0, 3));
            roff = int'($urandom_range(0, 3));
            rm   = 1'($urandom_range(0, 1));
            tot  = total_len(rc, ron, roff);
            mute = rm;
            start_req(rc, ron, roff);
            for (int j = 0; j <= tot + 1; j++) begin
                chk("rand beep", int'(beep), exp_beep(j, rc, ron, roff, rm));
                chk("rand busy", int'(busy), (j < tot) ? 1 : 0);
                chk("rand done", int'(done), (j == tot) ? 1 : 0);
                chk("rand ready", int'(bus.req_ready), (j >= tot) ? 1 : 0);
                bus.req_count  = 4'($urandom_range(0, 15));
                bus.req_on_ms  = 8'($urandom_range(0, 255));
                bus.req_off_ms = 8'($urandom_range(0, 255));
                @(negedge sys_clk);
            end
            mute = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
